ets_delay_sequencer: RTL
========================

# ets_delay_sequencer

Sweeps the 8-bit dynamic-delay code of `ets_clkgen` across a programmed range for equivalent-time sampling. After each delay change it waits a fixed PLL settling interval, then issues one or more capture requests to the sample-capture engine before advancing. It sits between the host-facing control registers and `ets_clkgen.delay`, and is the only writer of that delay code.

## Interface
- `SETTLE_CYCLES`, default 64: `clk` cycles waited after every delay-code change before the first capture request; legal range 1..65535.
- `REPEATS`, default 1: captures per delay step; legal range 1..255.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: single-cycle sweep request; sampled only in IDLE.
- `abort` input, 1 bit: terminates an in-progress sweep.
- `first` input, 8 bits: first delay code; sampled with `start`.
- `last` input, 8 bits: final delay code, inclusive; sampled with `start`.
- `incr` input, 4 bits: step size; 0 is treated as 1; sampled with `start`.
- `capture_ack` input, 1 bit: capture engine accepted the current request.
- `delay` output, 8 bits: drives `ets_clkgen.delay`; registered.
- `capture_req` output, 1 bit: request one capture at the current `delay`.
- `busy` output, 1 bit: high from the cycle after an accepted `start` until the cycle DONE is entered.
- `done` output, 1 bit: one-cycle pulse at sweep end, normal or aborted.
- `error` output, 1 bit: valid with `done`; high if `first > last` or if the sweep was aborted.

## Operation
- States: IDLE, SETTLE, CAPTURE, GAP, ADVANCE, DONE.
- IDLE, `start` high:
  - `first > last`: go to DONE with `error` set. No capture is issued and `delay` is unchanged.
  - Otherwise: latch `first`, `last` and `incr`; load `delay <= first`; clear the repeat counter; go to SETTLE.
- SETTLE: the settle counter runs for SETTLE_CYCLES cycles, then the block goes to CAPTURE.
- CAPTURE:
  - `capture_req` is high.
  - When `capture_ack` is high, the repeat counter increments.
  - If the count has reached REPEATS, go to ADVANCE; otherwise go to GAP.
- GAP: one cycle with `capture_req` low, then back to CAPTURE. The block does not settle again.
- ADVANCE:
  - Compute the 9-bit sum `delay + incr`.
  - If the sum exceeds `last`, or exceeds 255 (wrap-around), go to DONE.
  - Otherwise set `delay` to the sum, clear the repeat counter, and go to SETTLE.
- DONE: `done` pulses for one cycle, then the block returns to IDLE.
- `abort` in SETTLE, CAPTURE, GAP or ADVANCE:
  - Next state is DONE with `error` set.
  - `capture_req` drops on the next cycle.
  - `delay` holds its value.
- `abort` and `capture_ack` in the same cycle: abort wins and the capture is not counted.
- `start` while not in IDLE is ignored. `abort` in IDLE or DONE is ignored.
- `delay` holds its last value in IDLE; it is never returned to a default.

## Timing
- Reset values: `delay`=0x00, `capture_req`=0, `busy`=0, `done`=0, `error`=0, state IDLE, all counters 0.
- `start` at edge N:
  - `delay`=`first` and `busy`=1 from N+1.
  - `capture_req` rises at N+1+SETTLE_CYCLES.
- `capture_req` and `capture_ack` are both seen at edge M:
  - `capture_req` is low from M+1 for exactly one cycle (GAP or ADVANCE).
  - On a delay step, the new `delay` appears at M+2, and the next `capture_req` at M+2+SETTLE_CYCLES.
- `capture_ack` while `capture_req` is low is ignored.
- `done` and `error` are registered and valid in the same cycle. `busy` is 0 during the `done` cycle.
- Reset asserted mid-sweep: all outputs return to reset values immediately and asynchronously. No `done` pulse is produced.

## Structure
- Shared package `ets_pkg` holds:
  - the state enum `ets_seq_state_t`;
  - `ETS_DELAY_W` = 8;
  - `ETS_INCR_W` = 4.
- Sub-module `ets_settle_timer`:
  - load/count-down timer of width `$clog2(SETTLE_CYCLES+1)`;
  - `expired` output;
  - reloaded on entry to SETTLE.

## Test plan
- SETTLE_CYCLES=4, REPEATS=1; `first`=0x10, `last`=0x13, `incr`=1; `capture_ack` tied high -> `delay` steps 0x10, 0x11, 0x12, 0x13, with exactly 4 captures and 4 cycles from each delay change to `capture_req`; one `done` pulse with `error`=0.
- `first`=0xF8, `last`=0xFF, `incr`=5 -> captures at 0xF8 and 0xFD only; no wrap to 0x02; `done`, `error`=0.
- `first`=0x20, `last`=0x10 -> `done` and `error` one cycle after `start`; no `capture_req`; `delay` unchanged.
- REPEATS=3; `capture_ack` delayed 2 cycles per request -> 3 requests per step, each separated by 1 low cycle, no re-settle between them.
- `abort` in the same cycle as the second `capture_ack` -> capture not counted; `capture_req` low next cycle; `done` and `error` pulse; `delay` held.
- Reset asserted during CAPTURE -> all outputs zero immediately; a later `start` runs a clean sweep.

Source files
------------

// File: rtl/ets_pkg.sv
// Shared types and widths for the equivalent-time sampling delay sequencer.
package ets_pkg;

  localparam int ETS_DELAY_W = 8;
  localparam int ETS_INCR_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_GAP,
    ST_ADVANCE,
    ST_DONE
  } ets_seq_state_t;

  // A zero step would stall the sweep forever, so it is promoted to one.
  function automatic logic [ETS_INCR_W-1:0] ets_eff_incr(input logic [ETS_INCR_W-1:0] incr);
    return (incr == '0) ? ETS_INCR_W'(1) : incr;
  endfunction

endpackage

// File: rtl/ets_delay_sequencer_if.sv
// Host control, capture handshake and delay-code signals of the sequencer.
interface ets_delay_sequencer_if;
  import ets_pkg::*;

  logic                   start;
  logic                   abort;
  logic [ETS_DELAY_W-1:0] first;
  logic [ETS_DELAY_W-1:0] last;
  logic [ETS_INCR_W-1:0]  incr;
  logic                   capture_ack;
  logic [ETS_DELAY_W-1:0] delay;
  logic                   capture_req;
  logic                   busy;
  logic                   done;
  logic                   error;

  modport master (
    output start, abort, first, last, incr, capture_ack,
    input  delay, capture_req, busy, done, error
  );

  modport slave (
    input  start, abort, first, last, incr, capture_ack,
    output delay, capture_req, busy, done, error
  );

endinterface

// File: rtl/ets_settle_timer.sv
// Count-down timer that measures the PLL settling interval after a delay change.
module ets_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  // Loading N-1 makes expired rise after exactly N cycles in SETTLE.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ets_delay_sequencer.sv
// Sweeps the ets_clkgen delay code across [first, last], settling after each
// change and issuing REPEATS capture requests per step.
module ets_delay_sequencer
  import ets_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned REPEATS       = 1
) (
  input logic                  clk,
  input logic                  reset,
  ets_delay_sequencer_if.slave bus
);

  localparam int         SUM_W      = ETS_DELAY_W + 1;
  localparam logic [7:0] REP_TARGET = 8'(REPEATS);

  ets_seq_state_t         state_q, state_d;
  logic [ETS_DELAY_W-1:0] delay_q, delay_d;
  logic [ETS_DELAY_W-1:0] last_q, last_d;
  logic [ETS_INCR_W-1:0]  incr_q, incr_d;
  logic [7:0]             rep_q, rep_d;
  logic [7:0]             rep_inc;
  logic [SUM_W-1:0]       next_sum;
  logic                   capture_req_q, capture_req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   in_sweep;
  logic                   settle_load;
  logic                   settle_expired;

  ets_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (settle_load),
    .expired(settle_expired)
  );

  assign in_sweep = state_q inside {ST_SETTLE, ST_CAPTURE, ST_GAP, ST_ADVANCE};
  assign rep_inc  = rep_q + 8'd1;
  // Nine bits so a step past 0xFF is seen as overflow instead of wrapping.
  assign next_sum = SUM_W'(delay_q) + SUM_W'(incr_q);

  always_comb begin
    // NOTE: every _d is given its hold value first so no branch of the case can infer a latch.
    state_d = state_q;
    delay_d = delay_q;
    last_d  = last_q;
    incr_d  = incr_q;
    rep_d   = rep_q;
    error_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.first > bus.last) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end else begin
            delay_d = bus.first;
            last_d  = bus.last;
            incr_d  = ets_eff_incr(bus.incr);
            rep_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_expired) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus.capture_ack) begin
          rep_d   = rep_inc;
          state_d = (rep_inc == REP_TARGET) ? ST_ADVANCE : ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_CAPTURE;
      end
      ST_ADVANCE: begin
        if (next_sum[ETS_DELAY_W] || (next_sum > SUM_W'(last_q))) begin
          state_d = ST_DONE;
        end else begin
          delay_d = next_sum[ETS_DELAY_W-1:0];
          rep_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything above, including a same-cycle acknowledge or step.
    if (in_sweep && bus.abort) begin
      state_d = ST_DONE;
      error_d = 1'b1;
      delay_d = delay_q;
      rep_d   = rep_q;
    end

    capture_req_d = (state_d == ST_CAPTURE);
    busy_d        = state_d inside {ST_SETTLE, ST_CAPTURE, ST_GAP, ST_ADVANCE};
    done_d        = (state_d == ST_DONE);
  end

  assign settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments let every _q update from the same pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      delay_q       <= '0;
      last_q        <= '0;
      incr_q        <= '0;
      rep_q         <= '0;
      capture_req_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      last_q        <= last_d;
      incr_q        <= incr_d;
      rep_q         <= rep_d;
      capture_req_q <= capture_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.delay       = delay_q;
  assign bus.capture_req = capture_req_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule
